fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a `fifo` instance among `NumReq` valid/ready requesters. Multi-beat packets are delimited by a per-requester `last` flag, and the grant is held from a packet's first accepted beat through its last, so packets never interleave in the FIFO. The data path is a combinational mux, which adds zero cycles of latency. Arbitration state (rotating priority pointer, lock) is registered.

## Interface
- `NumReq`, 4: number of requesters; must be >= 2, elaboration `$error` otherwise; need not be a power of two.
- `Width`, 32: payload width; matches the downstream FIFO `Width`.
- `IdWidth`, `$clog2(NumReq)`: localparam; width of the requester index.

- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `req_valid_i` input NumReq: per-requester valid.
- `req_data_i` input NumReq*Width: requester i occupies bits `[i*Width +: Width]`.
- `req_last_i` input NumReq: per-requester end-of-packet flag, qualified by valid.
- `req_ready_o` output NumReq: per-requester ready; `req_ready_o[i] = grant_o[i] && out_ready_i`.
- `out_valid_o` output 1: to the FIFO `wr_valid_i`.
- `out_data_o` output Width: to the FIFO `wr_data_i`.
- `out_last_o` output 1: `last` of the granted requester; sideband for the consumer.
- `out_ready_i` input 1: from the FIFO `wr_ready_o`.
- `grant_o` output NumReq: one-hot current grant; all zero when nothing is granted.
- `grant_id_o` output IdWidth: index of the granted requester; 0 when nothing is granted.

## Operation
- **State.**
  - `state_q` is one of {IDLE, LOCKED}.
  - `ptr_q` (IdWidth) is the highest-priority requester index.
  - `lock_id_q` (IdWidth) is the requester holding the grant.
- **Requester rule.** A requester holds valid, data and last stable until its beat is accepted.
- **IDLE selection.**
  - `sel` = first i with `req_valid_i[i]`, searching `ptr_q`, `ptr_q+1`, … modulo `NumReq`.
  - If no requester is valid: `grant_o = 0`, `out_valid_o = 0`.
- **LOCKED selection.**
  - `sel = lock_id_q`, regardless of other requesters.
  - `out_valid_o = req_valid_i[lock_id_q]`; a gap in the locked requester's valid keeps the lock.
- **Outputs.** `out_data_o` and `out_last_o` are the slices of `sel`.
  - When nothing is granted, both are driven to 0.
- **Handshake.** `fire = out_valid_o && out_ready_i`.
- **Transitions.**
  - IDLE → LOCKED when `out_valid_o && (!out_ready_i || !out_last_o)`: a stalled beat or a non-final beat. `lock_id_q <= sel`.
    - A stalled first beat therefore cannot be pre-empted by a higher-priority arrival, so output data stays stable until accepted.
  - IDLE, `fire && out_last_o`: single-beat packet. Stay IDLE; `ptr_q <= sel+1` (wrap).
  - LOCKED, `fire && out_last_o`: go to IDLE; `ptr_q <= lock_id_q+1` (wrap).
  - LOCKED, otherwise: hold.
- **Pointer wrap.** `NumReq-1` wraps to 0 by explicit compare, not by bit overflow, so non-power-of-two `NumReq` is correct.
- **Fairness.** `ptr_q` advances only on a completed packet, giving packet-level round-robin. Any continuously valid requester is granted within `NumReq-1` packets.
- **Full FIFO.** `out_ready_i = 0` forces all `req_ready_o` to 0. Grant and state freeze, apart from the IDLE→LOCKED capture above.

## Timing
- **Reset.** Asserting `rst_ni` low immediately sets `state_q = IDLE`, `ptr_q = 0`, `lock_id_q = 0`.
- **Outputs during reset** are a pure function of the inputs and the reset state. `out_valid_o` and `req_ready_o` follow requester 0's priority; the FIFO is itself in reset.
- **Mid-packet reset.** Reset asserted mid-packet drops the lock. The partial packet already written is the FIFO's concern, since the FIFO is reset alongside.
- **Latency.** Zero-cycle combinational path from `req_*` to `out_*` and from `out_ready_i` to `req_ready_o`; no combinational loop.
- **Grant updates.** A new grant takes effect in the cycle after the `last` handshake. A back-to-back different requester beat is accepted in that next cycle, so there is no bubble.
- **Registers.** All state updates on the rising edge of `clk_i`.

## Test plan
- **Single-beat round-robin.** `NumReq=4`, all valid, `last=1`, `out_ready_i=1` → grants 0,1,2,3,0 on consecutive cycles; one beat per cycle; data matches the source.
- **Packet lock.** Req 2 sends 3 beats (last on beat 3) while req 0 is valid throughout → grant_id stays 2 for 3 fires, then 0. `ptr_q` becomes 3 after req 2's packet and 1 after req 0's.
- **Backpressure.** `out_ready_i=0` for 4 cycles with req 1 valid (`last=1`), then req 0 asserts → grant stays 1 and `out_data_o` is stable. Req 1's beat fires when ready rises; req 0 fires the next cycle.
- **Non-power-of-two wrap.** `NumReq=3`, all valid, single-beat → grants 0,1,2,0,1.
- **Async reset.** Drop `rst_ni` low asynchronously while LOCKED on req 3 mid-packet → state IDLE and `ptr_q=0` before the next edge. With reqs 0 and 3 valid after release, req 0 is granted first.
- **Valid gap.** LOCKED req 1 deasserts valid for 2 cycles while req 2 is valid → `out_valid_o=0` and `grant_o` remains one-hot on req 1 during the gap. Req 2 is granted only after req 1's last beat.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Packet-level round-robin arbiter sharing one FIFO write port
//               among NumReq valid/ready requesters; grant held per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter  int NumReq  = 4,
    parameter  int Width   = 32,
    localparam int IdWidth = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*Width-1:0] req_data_i,
    input  logic [NumReq-1:0]       req_last_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic                    out_valid_o,
    output logic [Width-1:0]        out_data_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i,
    output logic [NumReq-1:0]       grant_o,
    output logic [IdWidth-1:0]      grant_id_o
);

    generate
        if (NumReq < 2) begin : g_param_check
            $error("fifo_wr_arbiter: NumReq must be >= 2");
        end
    endgenerate

    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_locked = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [IdWidth-1:0] r_ptr;
    logic [IdWidth-1:0] w_ptr_nxt;
    logic [IdWidth-1:0] r_lock_id;
    logic [IdWidth-1:0] w_lock_id_nxt;

    logic               w_rr_found;
    logic [IdWidth-1:0] w_rr_id;
    logic               w_granted;
    logic [IdWidth-1:0] w_sel;
    logic               w_fire;

    // Explicit compare keeps the wrap correct for non-power-of-two NumReq.
    function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] id);
        return (id == IdWidth'(NumReq - 1)) ? '0 : id + IdWidth'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_idle;
            r_ptr     <= '0;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_id_nxt = r_lock_id;
        case (r_state)
            c_idle: begin
                // A stalled first beat is captured too, so a later, higher
                // priority arrival cannot swap the data under the FIFO.
                if (out_valid_o && (!out_ready_i || !out_last_o)) begin
                    w_state_nxt   = c_locked;
                    w_lock_id_nxt = w_sel;
                end else if (w_fire && out_last_o) begin
                    w_ptr_nxt = wrap_inc(w_sel);
                end
            end
            c_locked: begin
                if (w_fire && out_last_o) begin
                    w_state_nxt = c_idle;
                    w_ptr_nxt   = wrap_inc(r_lock_id);
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_comb begin
        // Two passes: lowest valid index at or above the pointer, else the
        // lowest valid index below it.
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!w_rr_found && req_valid_i[i] && (IdWidth'(i) >= r_ptr)) begin
                w_rr_found = 1'b1;
                w_rr_id    = IdWidth'(i);
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!w_rr_found && req_valid_i[i] && (IdWidth'(i) < r_ptr)) begin
                w_rr_found = 1'b1;
                w_rr_id    = IdWidth'(i);
            end
        end

        w_granted   = (r_state == c_locked) || w_rr_found;
        w_sel       = (r_state == c_locked) ? r_lock_id : w_rr_id;
        out_valid_o = (r_state == c_locked) ? req_valid_i[r_lock_id] : w_rr_found;

        out_data_o = '0;
        out_last_o = 1'b0;
        grant_o    = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_granted && (w_sel == IdWidth'(i))) begin
                out_data_o = req_data_i[i*Width +: Width];
                out_last_o = req_last_i[i];
                grant_o[i] = 1'b1;
            end
        end

        grant_id_o  = w_granted ? w_sel : '0;
        req_ready_o = grant_o & {NumReq{out_ready_i}};
        w_fire      = out_valid_o && out_ready_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed bench for fifo_wr_arbiter (NumReq=4 and NumReq=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   v4 = '0, l4 = '0;
    logic [127:0] d4 = '0;
    logic         rdy4 = 1'b0;
    logic [3:0]   rr4, g4;
    logic         ov4, ol4;
    logic [31:0]  od4;
    logic [1:0]   gid4;

    logic [2:0]   v3 = '0, l3 = '0;
    logic [23:0]  d3 = '0;
    logic         rdy3 = 1'b0;
    logic [2:0]   rr3, g3;
    logic         ov3, ol3;
    logic [7:0]   od3;
    logic [1:0]   gid3;

    fifo_wr_arbiter #(.NumReq(4), .Width(32)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v4), .req_data_i(d4), .req_last_i(l4), .req_ready_o(rr4),
        .out_valid_o(ov4), .out_data_o(od4), .out_last_o(ol4), .out_ready_i(rdy4),
        .grant_o(g4), .grant_id_o(gid4)
    );

    fifo_wr_arbiter #(.NumReq(3), .Width(8)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v3), .req_data_i(d3), .req_last_i(l3), .req_ready_o(rr3),
        .out_valid_o(ov3), .out_data_o(od3), .out_last_o(ol3), .out_ready_i(rdy3),
        .grant_o(g3), .grant_id_o(gid3)
    );

    int errors = 0;
    int checks = 0;

    // Model state per instance: [0] = 4 requesters, [1] = 3 requesters.
    int m_ptr[2]   = '{0, 0};
    int m_busy[2]  = '{0, 0};
    int m_owner[2] = '{0, 0};
    int n_ptr[2]   = '{0, 0};
    int n_busy[2]  = '{0, 0};
    int n_owner[2] = '{0, 0};

    int log4[$];
    int log3[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input int n, input int w,
                              input logic [3:0] valid, input logic [127:0] data,
                              input logic [3:0] last, input logic ready,
                              input logic [3:0] a_rr, input logic a_ov,
                              input logic [31:0] a_od, input logic a_ol,
                              input logic [3:0] a_g, input logic [1:0] a_gid);
        int           sel;
        bit           granted;
        logic         e_valid, e_last, fire;
        logic [127:0] mask, e_data;
        logic [3:0]   e_grant, e_rr;
        string        p;
        p       = (k == 0) ? "n4" : "n3";
        granted = 1'b0;
        sel     = 0;
        if (m_busy[k] != 0) begin
            granted = 1'b1;
            sel     = m_owner[k];
        end else begin
            for (int j = 0; j < n; j++) begin
                int i;
                i = (m_ptr[k] + j) % n;
                if (!granted && valid[i]) begin
                    granted = 1'b1;
                    sel     = i;
                end
            end
        end
        mask    = (128'd1 << w) - 128'd1;
        e_valid = (m_busy[k] != 0) ? valid[sel] : granted;
        e_data  = granted ? ((data >> (sel * w)) & mask) : 128'd0;
        e_last  = granted ? last[sel] : 1'b0;
        e_grant = granted ? (4'b0001 << sel) : 4'b0000;
        e_rr    = ready ? e_grant : 4'b0000;
        chk({p, ".out_valid"}, 128'(a_ov), 128'(e_valid));
        chk({p, ".out_data"},  128'(a_od), e_data);
        chk({p, ".out_last"},  128'(a_ol), 128'(e_last));
        chk({p, ".grant"},     128'(a_g),  128'(e_grant));
        chk({p, ".grant_id"},  128'(a_gid), granted ? 128'(sel) : 128'd0);
        chk({p, ".req_ready"}, 128'(a_rr), 128'(e_rr));

        fire       = e_valid && ready;
        n_ptr[k]   = m_ptr[k];
        n_busy[k]  = m_busy[k];
        n_owner[k] = m_owner[k];
        if (m_busy[k] == 0) begin
            if (e_valid && (!ready || !e_last)) begin
                n_busy[k]  = 1;
                n_owner[k] = sel;
            end else if (fire && e_last) begin
                n_ptr[k] = (sel + 1) % n;
            end
        end else if (fire && e_last) begin
            n_busy[k] = 0;
            n_ptr[k]  = (m_owner[k] + 1) % n;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, 32, v4, d4, l4, rdy4, rr4, ov4, od4, ol4, g4, gid4);
        model_step(1, 3, 8, {1'b0, v3}, {104'b0, d3}, {1'b0, l3}, rdy3,
                   {1'b0, rr3}, ov3, {24'b0, od3}, ol3, {1'b0, g3}, gid3);
        if (rst_n && ov4 && rdy4) log4.push_back(int'(gid4));
        if (rst_n && ov3 && rdy3) log3.push_back(int'(gid3));
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ptr[k]   = 0;
                m_busy[k]  = 0;
                m_owner[k] = 0;
            end else begin
                m_ptr[k]   = n_ptr[k];
                m_busy[k]  = n_busy[k];
                m_owner[k] = n_owner[k];
            end
        end
    end

    function automatic logic [31:0] pack(input int q[$]);
        logic [31:0] r;
        r = '0;
        foreach (q[i]) r = (r << 4) | 32'(q[i]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then outputs during reset follow pointer 0.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.grant_id", 128'(gid4), 128'd0);
        chk("rst.grant", 128'(g4), 128'd0);
        chk("rst.out_valid", 128'(ov4), 128'd0);
        v4 = 4'b0100; rdy4 = 1'b1;
        #1;
        chk("rst.grant_id_live", 128'(gid4), 128'd2);
        chk("rst.req_ready_live", 128'(rr4), 128'h4);
        v4 = 4'b0000; rdy4 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single-beat round robin on both instances.
        v4 = 4'hF; l4 = 4'hF; rdy4 = 1'b1;
        d4 = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        v3 = 3'h7; l3 = 3'h7; rdy3 = 1'b1;
        d3 = {8'h33, 8'h22, 8'h11};
        #1;
        chk("rr.first_data", 128'(od4), 128'hD0D0_0000);
        repeat (5) tick();
        v4 = '0; v3 = '0;
        chk("rr4.count", 128'(log4.size()), 128'd5);
        chk("rr4.order", 128'(pack(log4)), 128'h01230);
        chk("rr3.count", 128'(log3.size()), 128'd5);
        chk("rr3.order", 128'(pack(log3)), 128'h01201);
        chk("rr4.ptr", 128'(m_ptr[0]), 128'd1);
        chk("rr3.ptr", 128'(m_ptr[1]), 128'd2);
        log4.delete(); log3.delete();

        // Packet lock: req 2 sends 3 beats while req 0 waits.
        v4 = 4'b0101; l4 = 4'b0001;
        d4[0 +: 32] = 32'hA000_0000; d4[64 +: 32] = 32'hB000_0001;
        tick();
        chk("lock.grant_id", 128'(gid4), 128'd2);
        d4[64 +: 32] = 32'hB000_0002;
        tick();
        d4[64 +: 32] = 32'hB000_0003; l4[2] = 1'b1;
        tick();
        v4[2] = 1'b0;
        chk("lock.ptr_after_req2", 128'(m_ptr[0]), 128'd3);
        chk("lock.next_grant", 128'(gid4), 128'd0);
        tick();
        v4 = '0;
        chk("lock.ptr_after_req0", 128'(m_ptr[0]), 128'd1);
        chk("lock.count", 128'(log4.size()), 128'd4);
        chk("lock.order", 128'(pack(log4)), 128'h2220);
        log4.delete();

        // Backpressure: req 1 stalled, req 0 arrives, grant must not move.
        rdy4 = 1'b0; v4 = 4'b0010; l4 = 4'b0010; d4[32 +: 32] = 32'hC000_0001;
        repeat (2) tick();
        v4[0] = 1'b1; l4[0] = 1'b1; d4[0 +: 32] = 32'hA000_0001;
        repeat (2) begin
            tick();
            chk("bp.grant_id", 128'(gid4), 128'd1);
            chk("bp.data", 128'(od4), 128'hC000_0001);
        end
        rdy4 = 1'b1;
        #1;
        chk("bp.ready_rise", 128'(rr4), 128'h2);
        tick();
        v4[1] = 1'b0;
        tick();
        v4 = '0;
        chk("bp.count", 128'(log4.size()), 128'd2);
        chk("bp.order", 128'(pack(log4)), 128'h10);
        log4.delete();

        // Valid gap inside a locked packet.
        v4 = 4'b0110; l4 = 4'b0100;
        d4[32 +: 32] = 32'hE000_0001; d4[64 +: 32] = 32'hF000_0002;
        tick();
        v4[1] = 1'b0;
        repeat (2) begin
            #1;
            chk("gap.out_valid", 128'(ov4), 128'd0);
            chk("gap.grant", 128'(g4), 128'h2);
            tick();
        end
        v4[1] = 1'b1; l4[1] = 1'b1; d4[32 +: 32] = 32'hE000_0002;
        tick();
        v4[1] = 1'b0;
        tick();
        v4 = '0;
        chk("gap.count", 128'(log4.size()), 128'd3);
        chk("gap.order", 128'(pack(log4)), 128'h112);
        log4.delete();

        // Asynchronous reset while locked on req 3 mid-packet.
        v4 = 4'b1001; l4 = 4'b0001;
        d4[96 +: 32] = 32'h3333_0001; d4[0 +: 32] = 32'hA000_0002;
        tick();
        chk("arst.locked", 128'(gid4), 128'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.grant_id", 128'(gid4), 128'd0);
        chk("arst.grant", 128'(g4), 128'h1);
        chk("arst.data", 128'(od4), 128'hA000_0002);
        log4.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        l4[3] = 1'b1;
        tick();
        v4[0] = 1'b0;
        tick();
        v4 = '0;
        chk("arst.count", 128'(log4.size()), 128'd2);
        chk("arst.order", 128'(pack(log4)), 128'h03);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
